// File: rtl/a2bus_capture_pkg.sv
// Shared types and helpers for the Apple II bus capture queue.
// An entry is one sampled bus cycle packed as {rw_n, addr, data}.
package a2bus_capture_pkg;

    typedef struct packed {
        logic        rw_n;
        logic [15:0] addr;
        logic [7:0]  data;
    } a2_capture_entry_t;

    localparam int A2_CAPTURE_ENTRY_W = 25;

    // Inclusive, unsigned 16-bit window test.
    function automatic logic addr_in_window(input logic [15:0] addr,
                                            input logic [15:0] lo,
                                            input logic [15:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/a2_sync_fifo.sv
// Generic first-word-fall-through FIFO with wrap-bit pointers and a registered level.
// Memory has no reset so it maps onto distributed RAM.
module a2_sync_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A push into a full FIFO is allowed when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o && !clear_i;
    assign do_push = push_i && (!full_o || do_pop) && !clear_i;

    // Masked when empty so the head reads as zero out of reset and after a flush.
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign level_o = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + ONE;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + ONE;
            end
            if (do_push && !do_pop) begin
                level_d = level_q + ONE;
            end else if (!do_push && do_pop) begin
                level_d = level_q - ONE;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/a2bus_capture_fifo.sv
// Filters sampled Apple II bus cycles against an address window and queues matches
// for a valid/ready consumer, with sticky overflow and a saturating drop counter.
module a2bus_capture_fifo
    import a2bus_capture_pkg::*;
#(
    parameter int          DEPTH         = 16,
    parameter logic [15:0] ADDR_LO       = 16'hC000,
    parameter logic [15:0] ADDR_HI       = 16'hC0FF,
    parameter bit          CAPTURE_READS = 1'b0
) (
    input  logic                          clk_logic_i,
    input  logic                          system_reset_i,
    input  logic                          strobe_i,
    input  logic [15:0]                   addr_i,
    input  logic [7:0]                    data_i,
    input  logic                          rw_n_i,
    input  logic                          clear_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [A2_CAPTURE_ENTRY_W-1:0] entry_o,
    output logic [$clog2(DEPTH):0]        level_o,
    output logic                          overflow_o,
    output logic [7:0]                    drop_count_o
);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic              match;
    logic              cap_valid_q, cap_valid_d;
    a2_capture_entry_t cap_entry_q, cap_entry_d;
    logic              pop;
    logic              drop;
    logic              overflow_q, overflow_d;
    logic [7:0]        drop_count_q, drop_count_d;
    logic              fifo_full;
    logic              fifo_empty;

    // Stage 1: window match and capture register.
    assign match = strobe_i && addr_in_window(addr_i, ADDR_LO, ADDR_HI) &&
                   (!rw_n_i || CAPTURE_READS);
    assign cap_valid_d = match && !clear_i;
    assign cap_entry_d = {rw_n_i, addr_i, data_i};

    always_ff @(posedge clk_logic_i or posedge system_reset_i) begin
        if (system_reset_i) begin
            cap_valid_q <= 1'b0;
        end else begin
            cap_valid_q <= cap_valid_d;
        end
    end

    always_ff @(posedge clk_logic_i) begin
        if (match) begin
            cap_entry_q <= cap_entry_d;
        end
    end

    // Stage 2: push into the queue, or account for a drop when it cannot take the entry.
    assign valid_o = !fifo_empty;
    assign pop     = valid_o && ready_i;
    assign drop    = cap_valid_q && fifo_full && !pop && !clear_i;

    always_comb begin
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (clear_i) begin
            overflow_d   = 1'b0;
            drop_count_d = 8'd0;
        end else if (drop) begin
            overflow_d   = 1'b1;
            drop_count_d = sat_inc8(drop_count_q);
        end
    end

    always_ff @(posedge clk_logic_i or posedge system_reset_i) begin
        if (system_reset_i) begin
            overflow_q   <= 1'b0;
            drop_count_q <= 8'd0;
        end else begin
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign overflow_o   = overflow_q;
    assign drop_count_o = drop_count_q;

    a2_sync_fifo #(
        .WIDTH (A2_CAPTURE_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_logic_i),
        .rst_i   (system_reset_i),
        .push_i  (cap_valid_q),
        .pop_i   (pop),
        .clear_i (clear_i),
        .wdata_i (cap_entry_q),
        .rdata_o (entry_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

endmodule

// File: tb/tb_a2bus_capture_fifo.sv
// Bench for a2bus_capture_fifo: vector table, directed corner sequences and
// randomized traffic checked every cycle against a queue-based reference model.
module tb_a2bus_capture_fifo;

    localparam int          DEPTH   = 16;
    localparam logic [15:0] ADDR_LO = 16'hC000;
    localparam logic [15:0] ADDR_HI = 16'hC0FF;
    localparam bit          CAP_RD  = 1'b0;

    logic        clk = 1'b0;
    logic        rst;
    logic        strobe, rw_n, clear, ready;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        valid;
    logic [24:0] entry;
    logic [4:0]  level;
    logic        ovf;
    logic [7:0]  dcnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [24:0] mq[$];
    bit          pend_v;
    logic [24:0] pend_e;
    bit          m_ovf;
    int          m_cnt;

    typedef struct {
        logic [15:0] a;
        logic        rw;
        logic [7:0]  d;
        bit          cap;
        logic [24:0] exp;
    } vec_t;
    vec_t tbl[9];

    always #5 clk = ~clk;

    a2bus_capture_fifo #(
        .DEPTH(DEPTH), .ADDR_LO(ADDR_LO), .ADDR_HI(ADDR_HI), .CAPTURE_READS(CAP_RD)
    ) dut (
        .clk_logic_i   (clk),
        .system_reset_i(rst),
        .strobe_i      (strobe),
        .addr_i        (addr),
        .data_i        (data),
        .rw_n_i        (rw_n),
        .clear_i       (clear),
        .valid_o       (valid),
        .ready_i       (ready),
        .entry_o       (entry),
        .level_o       (level),
        .overflow_o    (ovf),
        .drop_count_o  (dcnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        pend_v = 0;
        m_ovf  = 0;
        m_cnt  = 0;
    endtask

    // One clock edge of the behavioural model, using the inputs seen at that edge.
    task automatic model_step(input bit stb, input logic [15:0] a, input logic [7:0] d,
                              input bit rw, input bit rdy, input bit clr);
        bit pop_now, push_ok;
        if (clr) begin
            model_reset();
            return;
        end
        pop_now = (mq.size() > 0) && rdy;
        push_ok = 0;
        if (pend_v) begin
            if (mq.size() < DEPTH || pop_now) push_ok = 1;
            else begin
                m_ovf = 1;
                if (m_cnt < 255) m_cnt++;
            end
        end
        if (pop_now) void'(mq.pop_front());
        if (push_ok) mq.push_back(pend_e);
        pend_v = stb && (a >= ADDR_LO) && (a <= ADDR_HI) && (!rw || CAP_RD);
        pend_e = {rw, a, d};
    endtask

    task automatic compare_model();
        chk("m_valid", valid, mq.size() != 0);
        chk("m_level", level, mq.size());
        chk("m_overflow", ovf, m_ovf);
        chk("m_drop_count", dcnt, m_cnt);
        if (mq.size() != 0) chk("m_entry", entry, mq[0]);
    endtask

    task automatic cycle(input bit stb, input logic [15:0] a, input logic [7:0] d,
                         input bit rw, input bit rdy, input bit clr);
        strobe = stb; addr = a; data = d; rw_n = rw; ready = rdy; clear = clr;
        @(posedge clk);
        model_step(stb, a, d, rw, rdy, clr || rst);
        #1;
        strobe = 0;
        clear  = 0;
        compare_model();
    endtask

    task automatic idle(input bit rdy);
        cycle(0, 16'h0000, 8'h00, 1'b0, rdy, 1'b0);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d, input bit rdy);
        cycle(1, a, d, 1'b0, rdy, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a16;
        logic [24:0] e25;

        tbl[0] = '{16'hC030, 1'b0, 8'h5A, 1'b1, 25'h0C0305A};
        tbl[1] = '{16'hBFFF, 1'b0, 8'h11, 1'b0, 25'h0};
        tbl[2] = '{16'hC010, 1'b1, 8'h22, 1'b0, 25'h0};
        tbl[3] = '{16'hC0FF, 1'b0, 8'h33, 1'b1, 25'h0C0FF33};
        tbl[4] = '{16'hC000, 1'b0, 8'h44, 1'b1, 25'h0C00044};
        tbl[5] = '{16'hC100, 1'b0, 8'h55, 1'b0, 25'h0};
        tbl[6] = '{16'h0000, 1'b0, 8'h66, 1'b0, 25'h0};
        tbl[7] = '{16'hFFFF, 1'b0, 8'h77, 1'b0, 25'h0};
        tbl[8] = '{16'hC0FF, 1'b1, 8'h88, 1'b0, 25'h0};

        rst = 1; strobe = 0; addr = 0; data = 0; rw_n = 0; clear = 0; ready = 0;
        model_reset();
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_entry", entry, 0);
        chk("rst_level", level, 0);
        chk("rst_overflow", ovf, 0);
        chk("rst_drop_count", dcnt, 0);
        idle(0);
        idle(0);
        rst = 0;
        idle(0);

        // First-entry latency
        wr(16'hC030, 8'h5A, 0);
        chk("lat_valid_edge1", valid, 0);
        idle(0);
        chk("lat_valid_edge2", valid, 1);
        chk("lat_entry", entry, 25'h0C0305A);
        chk("lat_level", level, 1);
        idle(1);
        chk("lat_level_after_pop", level, 0);

        // Address/direction filter table
        for (int i = 0; i < 9; i++) begin
            cycle(1, tbl[i].a, tbl[i].d, tbl[i].rw, 1'b0, 1'b0);
            idle(0);
            chk("tbl_valid", valid, tbl[i].cap);
            chk("tbl_level", level, tbl[i].cap);
            if (tbl[i].cap) chk("tbl_entry", entry, tbl[i].exp);
            idle(1);
        end

        // 18 back-to-back writes into 16 entries, then drain in order
        cycle(0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 18; i++) begin
            a16 = 16'hC000 + 16'(i);
            wr(a16, 8'(i), 0);
        end
        idle(0);
        idle(0);
        chk("ovf_level", level, 16);
        chk("ovf_flag", ovf, 1);
        chk("ovf_drop_count", dcnt, 2);
        for (int i = 0; i < 16; i++) begin
            a16 = 16'hC000 + 16'(i);
            e25 = {1'b0, a16, 8'(i)};
            chk("drain_entry", entry, e25);
            idle(1);
        end
        chk("drain_level", level, 0);
        chk("drain_valid", valid, 0);

        // Full FIFO with a pop on the cycle the push lands
        cycle(0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            a16 = 16'hC080 + 16'(i);
            wr(a16, 8'(i + 100), 0);
        end
        idle(0);
        idle(0);
        chk("full_level", level, 16);
        wr(16'hC0AA, 8'hAB, 0);
        idle(1);
        chk("full_pop_level", level, 16);
        chk("full_pop_drop_count", dcnt, 0);
        chk("full_pop_overflow", ovf, 0);
        chk("full_pop_head", entry, 25'h0C08165);

        // Drop counter saturation, then clear with a coincident strobe
        for (int i = 0; i < 300; i++) wr(16'hC0C0, 8'(i), 0);
        idle(0);
        chk("sat_drop_count", dcnt, 255);
        chk("sat_overflow", ovf, 1);
        cycle(1, 16'hC050, 8'h77, 1'b0, 1'b0, 1'b1);
        chk("clr_valid", valid, 0);
        chk("clr_level", level, 0);
        chk("clr_overflow", ovf, 0);
        chk("clr_drop_count", dcnt, 0);
        chk("clr_entry", entry, 0);
        idle(0);
        idle(0);
        chk("clr_no_entry_valid", valid, 0);
        chk("clr_no_entry_level", level, 0);

        // Asynchronous reset with a capture in flight
        for (int i = 0; i < 3; i++) wr(16'hC020, 8'(i), 0);
        idle(0);
        idle(0);
        chk("pre_rst_level", level, 3);
        wr(16'hC060, 8'h12, 0);
        #2 rst = 1;
        #1;
        model_reset();
        chk("arst_valid", valid, 0);
        chk("arst_level", level, 0);
        chk("arst_entry", entry, 0);
        idle(0);
        rst = 0;
        idle(0);
        chk("post_rst_level", level, 0);
        wr(16'hC070, 8'h34, 0);
        idle(0);
        chk("post_rst_valid", valid, 1);
        chk("post_rst_entry", entry, 25'h0C07034);
        idle(1);

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            bit stb, rw, rdy, clr;
            logic [15:0] ra;
            stb = ($urandom_range(0, 99) < 55);
            rw  = $urandom_range(0, 3) == 0;
            rdy = ($urandom_range(0, 99) < ((i / 250) % 2 == 0 ? 30 : 70));
            clr = ($urandom_range(0, 199) == 0);
            ra  = 16'($urandom_range(32'hBFF0, 32'hC10F));
            cycle(stb, ra, 8'($urandom), rw, rdy, clr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
